alu_sweep_ctrl: RTL

- Sequential initiator for the 4-bit ALU; drives its A/B/ctrl inputs and collects rst/carry/zero/overflow.
- On a start pulse, latches one operand pair and issues every opcode enabled in a mask, in ascending order 0..7.
- Streams one result record per issued op over a valid/ready output.
- Sits between the board-level input logic (switches/keys) and the display/consumer logic.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_golden_model.sv | 52 +++++
 rtl/alu_sweep_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sweep controller: opcodes, flag bit
// positions inside a result record, and the controller state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    // Flags travel as {carry, zero, overflow}.
    localparam int FLG_C = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUT     = 3'd3,
        S_FIN     = 3'd4
    } state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference of the 4-bit ALU, used to cross-check the real
// ALU while a sweep runs. Only instantiated when ALU_SELFCHECK_EN is defined.
import alu_pkg::*;

module alu_golden_model #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   ctrl,
    output logic [W-1:0] res,
    output logic [2:0]   flags
);

    logic [W:0] sum;
    logic [W:0] dif;
    logic       c;
    logic       v;

    // Reference result and flags; LT/EQ return a single bit, so zero = ~r0 = (r==0).
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                res = sum[W-1:0];
                c   = sum[W];
                v   = (a[W-1] == b[W-1]) && (a[W-1] != sum[W-1]);
            end
            OP_SUB: begin
                res = dif[W-1:0];
                c   = dif[W];
                v   = (a[W-1] == ~b[W-1]) && (a[W-1] != dif[W-1]);
            end
            OP_NOT: res = ~a;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_LT:  res = W'(dif[W-1]);
            OP_EQ:  res = W'(a == b);
            default: res = '0;
        endcase
        flags        = 3'b000;
        flags[FLG_C] = c;
        flags[FLG_Z] = (res == '0);
        flags[FLG_V] = v;
    end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sweep initiator for the 4-bit ALU: latches an operand pair on start and
// issues every opcode enabled in the mask, lowest first, streaming one
// {op, result, flags} record per opcode over a valid/ready port.
// Optional build macro ALU_SELFCHECK_EN adds a golden-model cross-check with
// sticky mismatch / err_op outputs.
import alu_pkg::*;

module alu_sweep_ctrl #(
    parameter  int W    = 4,
    parameter  int NOPS = 8,
    localparam int CW   = $clog2(NOPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    a_in,
    input  logic [W-1:0]    b_in,
    input  logic [NOPS-1:0] op_mask,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [CW-1:0]   alu_ctrl,
    input  logic [W-1:0]    alu_res,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CW-1:0]   res_op,
    output logic [W-1:0]    res_data,
    output logic [2:0]      res_flags,
    output logic            busy,
    output logic            done
`ifdef ALU_SELFCHECK_EN
    ,
    output logic            mismatch,
    output logic [CW-1:0]   err_op
`endif
);

    state_t          state;
    state_t          state_nx;
    logic [NOPS-1:0] mask_q;
    logic [CW-1:0]   pick;
    logic            accept;
    logic [2:0]      alu_flags;

    assign alu_flags = {alu_carry, alu_zero, alu_overflow};

    // Lowest set bit of the remaining mask (scan high to low, last hit wins).
    always_comb begin
        pick = '0;
        for (int i = NOPS - 1; i >= 0; i--) begin
            if (mask_q[i]) pick = CW'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; an empty mask on start never leaves IDLE.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (op_mask != '0)) begin
                    accept   = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_OUT;
            S_OUT: begin
                if (res_ready) state_nx = (mask_q != '0) ? S_ISSUE : S_FIN;
            end
            S_FIN:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Operand/opcode drive, record capture and busy/done; done is registered so it lines up with FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            mask_q    <= '0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_data  <= '0;
            res_flags <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a  <= a_in;
                        alu_b  <= b_in;
                        mask_q <= op_mask;
                        busy   <= 1'b1;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    alu_ctrl     <= pick;
                    mask_q[pick] <= 1'b0;
                end
                S_CAPTURE: begin
                    res_data  <= alu_res;
                    res_flags <= alu_flags;
                    res_op    <= alu_ctrl;
                    res_valid <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (mask_q == '0) done <= 1'b1;
                    end
                end
                S_FIN:   busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ALU_SELFCHECK_EN
    logic [W-1:0] gold_res;
    logic [2:0]   gold_flags;

    alu_golden_model #(.W(W)) u_gold (
        .a     (alu_a),
        .b     (alu_b),
        .ctrl  (alu_ctrl),
        .res   (gold_res),
        .flags (gold_flags)
    );

    // Sticky record of the first opcode whose ALU output disagrees with the model.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            err_op   <= '0;
        end else if (accept) begin
            mismatch <= 1'b0;
            err_op   <= '0;
        end else if ((state == S_CAPTURE) && !mismatch &&
                     ((alu_res != gold_res) || (alu_flags != gold_flags))) begin
            mismatch <= 1'b1;
            err_op   <= alu_ctrl;
        end
    end
`endif

endmodule
